// File: rtl/xor_stream_checksum_pkg.sv
// Shared types and helpers for the streaming XOR checksum engine.
package xor_pkg;

  // FSM states of the checksum engine.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_e;

  // Fold modes as seen on the mode input; 2'b11 is reserved and folded into MODE_XOR.
  typedef enum logic [1:0] {
    MODE_XOR    = 2'b00,
    MODE_XNOR   = 2'b01,
    MODE_ROTXOR = 2'b10
  } mode_e;

  // Widest word the rotate helper supports.
  localparam int ROT_MAX_W = 64;

  // Rotate the low w bits of v left by one; bits at and above w come back as zero.
  function automatic logic [ROT_MAX_W-1:0] rotl1(input logic [ROT_MAX_W-1:0] v, input int w);
    logic [ROT_MAX_W-1:0] mask;
    mask = (ROT_MAX_W'(1) << w) - ROT_MAX_W'(1);
    return ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/xor_stream_checksum_fold_step.sv
// Combinational fold of one input word into the running accumulator.
module xor_fold_step
  import xor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] data_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] acc_o
);

  // Plain XOR for XOR/XNOR (the XNOR inversion is applied once at the end), rotate-then-XOR otherwise.
  always_comb begin
    // NOTE: assign a default before any branch so every path drives acc_o and no latch is inferred.
    acc_o = acc_i ^ data_i;
    if (mode_i == MODE_ROTXOR) begin
      acc_o = WIDTH'(rotl1(ROT_MAX_W'(acc_i), WIDTH)) ^ data_i;
    end
  end

endmodule

// File: rtl/xor_stream_checksum.sv
// Streaming XOR checksum engine: folds a packet of words into a checksum and
// presents sum, parity, word count and overflow on a held output handshake.
module xor_stream_checksum
  import xor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_parity_q, out_parity_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic             accept;
  logic             enter_hold;
  logic [WIDTH-1:0] fold_acc;
  mode_e            mode_in;

  assign accept     = in_valid && in_ready_q;
  assign enter_hold = accept && in_last && (state_q != HOLD);
  assign mode_in    = (mode == 2'b11) ? MODE_XOR : mode_e'(mode);

  xor_fold_step #(
    .WIDTH (WIDTH)
  ) u_fold (
    .acc_i  (acc_q),
    .data_i (in_data),
    .mode_i (mode_q),
    .acc_o  (fold_acc)
  );

  // State and datapath registers; reset discards any partial packet and pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= MODE_XOR;
      acc_q        <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_parity_q <= 1'b0;
      out_count_q  <= '0;
      out_ovf_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
      state_q      <= state_d;
      mode_q       <= mode_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_sum_q    <= out_sum_d;
      out_parity_q <= out_parity_d;
      out_count_q  <= out_count_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

  // Next-state: start/continue a packet on accepted beats, leave HOLD when the result is taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) state_d = in_last ? HOLD : ACCUM;
      end
      HOLD: begin
        if (out_valid_q && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Accumulator, counter and result registers; outputs only reload when entering HOLD.
  always_comb begin
    mode_d       = mode_q;
    acc_d        = acc_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    out_valid_d  = out_valid_q;
    out_sum_d    = out_sum_q;
    out_parity_d = out_parity_q;
    out_count_d  = out_count_q;
    out_ovf_d    = out_ovf_q;

    if (accept && state_q == IDLE) begin
      acc_d   = in_data;
      count_d = CNT_ONE;
      mode_d  = mode_in;
      ovf_d   = 1'b0;
    end else if (accept && state_q == ACCUM) begin
      acc_d = fold_acc;
      if (count_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end

    if (enter_hold) begin
      out_sum_d    = (mode_d == MODE_XNOR) ? ~acc_d : acc_d;
      out_parity_d = ^out_sum_d;
      out_count_d  = count_d;
      out_ovf_d    = ovf_d;
      out_valid_d  = 1'b1;
    end else if (state_q == HOLD && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Input ready is registered from the next state only, so out_ready never reaches it combinationally.
  always_comb begin
    in_ready_d = (state_d != HOLD);
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign out_parity = out_parity_q;
  assign out_count  = out_count_q;
  assign out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_xor_stream_checksum.sv
// Directed testbench for xor_stream_checksum: table-driven packets plus
// hand-written handshake, reset and overflow sequences.
module tb_xor_stream_checksum;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, out_parity, out_ovf;
  logic [7:0] out_sum, out_count;

  logic       o_in_ready, o_out_valid, o_out_parity, o_out_ovf;
  logic [7:0] o_out_sum;
  logic [2:0] o_out_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  xor_stream_checksum #(.WIDTH(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_parity (out_parity),
    .out_count  (out_count),
    .out_ovf    (out_ovf)
  );

  xor_stream_checksum #(.WIDTH(8), .CNT_W(3)) dut_ovf (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (o_in_ready),
    .out_valid  (o_out_valid),
    .out_ready  (out_ready),
    .out_sum    (o_out_sum),
    .out_parity (o_out_parity),
    .out_count  (o_out_count),
    .out_ovf    (o_out_ovf)
  );

  typedef struct packed {
    logic [1:0]      mode;
    logic [2:0]      n;
    logic [3:0][7:0] w;
    logic [7:0]      sum;
    logic            par;
    logic [7:0]      cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One beat: drive at the falling edge, wait (bounded) for in_ready, accepted on the next rising edge.
  task automatic send_beat(input logic [1:0] m, input logic [7:0] d, input logic last);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    mode     = m;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Accept the held result, then confirm the engine is back in IDLE.
  task automatic ack(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({name, "_ack_valid"}, 32'(out_valid), 32'd0);
    check({name, "_ack_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{mode: 2'b00, n: 3'd3, w: {8'h00, 8'h33, 8'hF0, 8'h0F}, sum: 8'hCC, par: 1'b0, cnt: 8'd3};
    vecs[1] = '{mode: 2'b01, n: 3'd3, w: {8'h00, 8'h33, 8'hF0, 8'h0F}, sum: 8'h33, par: 1'b0, cnt: 8'd3};
    vecs[2] = '{mode: 2'b10, n: 3'd2, w: {8'h00, 8'h00, 8'h01, 8'h81}, sum: 8'h02, par: 1'b1, cnt: 8'd2};
    vecs[3] = '{mode: 2'b00, n: 3'd1, w: {8'h00, 8'h00, 8'h00, 8'hA5}, sum: 8'hA5, par: 1'b0, cnt: 8'd1};
    vecs[4] = '{mode: 2'b11, n: 3'd2, w: {8'h00, 8'h00, 8'h34, 8'h12}, sum: 8'h26, par: 1'b1, cnt: 8'd2};
    vecs[5] = '{mode: 2'b10, n: 3'd3, w: {8'h00, 8'h00, 8'h00, 8'h80}, sum: 8'h02, par: 1'b1, cnt: 8'd3};
    vecs[6] = '{mode: 2'b01, n: 3'd1, w: {8'h00, 8'h00, 8'h00, 8'hFF}, sum: 8'h00, par: 1'b0, cnt: 8'd1};

    // Reset state.
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven packets, back to back at one word per cycle.
    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < int'(vecs[i].n); b++) begin
        send_beat(vecs[i].mode, vecs[i].w[b], b == int'(vecs[i].n) - 1);
      end
      @(negedge clk);
      check($sformatf("vec%0d_valid", i),  32'(out_valid),  32'd1);
      check($sformatf("vec%0d_ready", i),  32'(in_ready),   32'd0);
      check($sformatf("vec%0d_sum", i),    32'(out_sum),    32'(vecs[i].sum));
      check($sformatf("vec%0d_parity", i), 32'(out_parity), 32'(vecs[i].par));
      check($sformatf("vec%0d_count", i),  32'(out_count),  32'(vecs[i].cnt));
      check($sformatf("vec%0d_ovf", i),    32'(out_ovf),    32'd0);
      ack($sformatf("vec%0d", i));
    end

    // Backpressure: result held stable for 5 cycles with in_ready low.
    send_beat(2'b00, 8'h5A, 1'b0);
    send_beat(2'b00, 8'h0F, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_ready", c), 32'(in_ready),  32'd0);
      check($sformatf("bp%0d_sum", c),   32'(out_sum),   32'h55);
      check($sformatf("bp%0d_count", c), 32'(out_count), 32'd2);
    end
    ack("bp");

    // Minimum bubble: out_ready already high still gives one HOLD cycle with in_ready low.
    out_ready = 1'b1;
    send_beat(2'b00, 8'h11, 1'b1);
    @(negedge clk);
    check("bubble_valid", 32'(out_valid), 32'd1);
    check("bubble_ready", 32'(in_ready),  32'd0);
    check("bubble_sum",   32'(out_sum),   32'h11);
    @(negedge clk);
    check("bubble_idle_valid", 32'(out_valid), 32'd0);
    check("bubble_idle_ready", 32'(in_ready),  32'd1);
    out_ready = 1'b0;

    // Idle gaps and mode changes inside a packet: only the first-beat mode counts.
    send_beat(2'b01, 8'h0F, 1'b0);
    repeat (2) @(negedge clk);
    check("gap_ready", 32'(in_ready), 32'd1);
    send_beat(2'b00, 8'hF0, 1'b0);
    @(negedge clk);
    send_beat(2'b10, 8'h33, 1'b1);
    @(negedge clk);
    check("gap_valid", 32'(out_valid), 32'd1);
    check("gap_sum",   32'(out_sum),   32'h33);
    check("gap_count", 32'(out_count), 32'd3);
    ack("gap");

    // Reset mid-packet: partial packet discarded.
    send_beat(2'b00, 8'hAA, 1'b0);
    send_beat(2'b00, 8'h55, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send_beat(2'b00, 8'h3C, 1'b1);
    @(negedge clk);
    check("rst_mid_new_valid", 32'(out_valid), 32'd1);
    check("rst_mid_new_sum",   32'(out_sum),   32'h3C);
    check("rst_mid_new_count", 32'(out_count), 32'd1);
    ack("rst_mid");

    // Reset while a result is held in HOLD.
    send_beat(2'b00, 8'h77, 1'b1);
    @(negedge clk);
    check("rst_hold_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_hold_valid",  32'(out_valid),  32'd0);
    check("rst_hold_ready",  32'(in_ready),   32'd1);
    check("rst_hold_sum",    32'(out_sum),    32'd0);
    check("rst_hold_parity", 32'(out_parity), 32'd0);
    check("rst_hold_count",  32'(out_count),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Overflow: 9 beats of 0x01; the 3-bit counter saturates at 7 and flags overflow.
    for (int b = 0; b < 9; b++) send_beat(2'b00, 8'h01, b == 8);
    @(negedge clk);
    check("ovf3_valid", 32'(o_out_valid), 32'd1);
    check("ovf3_count", 32'(o_out_count), 32'd7);
    check("ovf3_ovf",   32'(o_out_ovf),   32'd1);
    check("ovf3_sum",   32'(o_out_sum),   32'h01);
    check("ovf8_count", 32'(out_count),   32'd9);
    check("ovf8_ovf",   32'(out_ovf),     32'd0);
    ack("ovf");

    // Overflow flag clears on the next packet.
    send_beat(2'b00, 8'h42, 1'b1);
    @(negedge clk);
    check("ovf3_clear_ovf",   32'(o_out_ovf),   32'd0);
    check("ovf3_clear_count", 32'(o_out_count), 32'd1);
    ack("ovf_clear");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/xor_stream_checksum.md
# xor_stream_checksum

Parametrised streaming XOR checksum engine, the sequential successor to the single-bit XOR gate. It accepts a packet of WIDTH-bit words over a valid/ready handshake and folds each word into an accumulator in one of three modes. On the last word it presents the checksum, its parity and the word count on a held output handshake. It sits between a packet source and any consumer needing integrity tags: link checks, memory scrub and self-test signatures.

## Interface
- WIDTH, 8: data and checksum width in bits, at least 2.
- CNT_W, 8: word-counter width; the count saturates at 2^CNT_W-1.
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- MODE  in  2  fold mode, sampled on the first beat of each packet:
  - 00: XOR.
  - 01: XNOR, XOR with the result inverted at the end.
  - 10: rotate-XOR.
  - 11: reserved, behaves as 00.
- IN_VALID  in  1  input word valid.
- IN_DATA  in  WIDTH  input word.
- IN_LAST  in  1  marks the final word of a packet.
- IN_READY  out  1  engine can accept a word.
- OUT_VALID  out  1  result valid, held until accepted.
- OUT_READY  in  1  consumer accepts the result.
- OUT_SUM  out  WIDTH  checksum.
- OUT_PARITY  out  1  XOR-reduction of OUT_SUM.
- OUT_COUNT  out  CNT_W  number of words in the packet.
- OUT_OVF  out  1  packet length exceeded 2^CNT_W-1.

## Operation
- The FSM has three states: IDLE, ACCUM and HOLD.
- A beat is accepted when IN_VALID and IN_READY are both high at a rising edge.
- IN_READY is high in IDLE and ACCUM and low in HOLD.
- IDLE, on a beat:
  - acc = IN_DATA, count = 1, MODE latched into mode_q, OUT_OVF cleared.
  - Go to HOLD if IN_LAST, otherwise ACCUM.
- ACCUM, on a beat:
  - XOR and XNOR modes: acc = acc ^ IN_DATA.
  - Rotate mode: acc = {acc[WIDTH-2:0], acc[WIDTH-1]} ^ IN_DATA, i.e. rotate left by 1, then XOR.
  - count increments, saturating; on saturation OUT_OVF sets and stays set for the packet.
  - Go to HOLD if IN_LAST.
- Entering HOLD:
  - OUT_SUM = acc, or ~acc when mode_q is XNOR.
  - OUT_PARITY = ^OUT_SUM; OUT_COUNT = count; OUT_VALID = 1.
- HOLD:
  - All outputs are held stable while OUT_READY is low.
  - On OUT_VALID and OUT_READY: OUT_VALID drops and the FSM returns to IDLE.
- Idle cycles inside a packet (IN_VALID low in ACCUM) do not change state.
- MODE changes mid-packet are ignored; only mode_q is used.
- Reset, including mid-packet or in HOLD:
  - State to IDLE; acc, count, OUT_SUM, OUT_COUNT to 0.
  - OUT_VALID, OUT_PARITY and OUT_OVF to 0; IN_READY to 1.
  - The partial packet is discarded.

## Timing
- Output latency: OUT_VALID rises on the edge that accepts the IN_LAST beat and is visible the following cycle.
- Throughput: one word per cycle within a packet.
- Between packets there is one bubble minimum: the HOLD cycle, with IN_READY low even when OUT_READY is already high.
- When OUT_READY is high in HOLD, the next packet's first beat is accepted one cycle later, in IDLE.
- IN_READY is a registered function of state only, with no combinational path from OUT_READY.
- OUT_* are registered and change only on entering HOLD or on reset.

## Structure
- Package xor_pkg holds:
  - typedef enum of the FSM states: IDLE, ACCUM, HOLD.
  - typedef enum logic [1:0] of the modes: MODE_XOR, MODE_XNOR, MODE_ROTXOR.
  - A function rotl1 for the rotate step.
- One sub-module, xor_fold_step: combinational next-accumulator from (acc, data, mode_q), parametrised on WIDTH.
- All remaining logic lives in the top module.

## Test plan
All scenarios use WIDTH=8 and CNT_W=8 unless stated.
- XOR, words 0x0F, 0xF0, 0x33 (last on the third) -> OUT_SUM=0xCC, OUT_PARITY=0, OUT_COUNT=3, OUT_VALID one cycle after the last beat.
- XNOR, same words -> OUT_SUM=0x33, OUT_PARITY=0, OUT_COUNT=3.
- Rotate-XOR, 0x81 then 0x01 (last) -> OUT_SUM=0x02, OUT_PARITY=1, OUT_COUNT=2.
- Single beat 0xA5 with IN_LAST, XOR -> OUT_SUM=0xA5, OUT_COUNT=1.
- Backpressure: hold OUT_READY low 5 cycles after OUT_VALID -> IN_READY=0 throughout, outputs unchanged. Raise OUT_READY -> IDLE next cycle, IN_READY=1.
- Reset mid-packet: after 2 of 4 beats, pulse RST_N low asynchronously -> OUT_VALID=0, IN_READY=1. A new 1-beat packet 0x3C gives OUT_SUM=0x3C, OUT_COUNT=1.
- Overflow: with CNT_W=3, send 9 beats of 0x01 -> OUT_COUNT=7, OUT_OVF=1, OUT_SUM=0x01.
